// File: rtl/arb_pkg.sv
// Shared definitions for the two-master AXI-Lite read arbiter:
// one-hot state encoding and master identifiers.
package arb_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'b001,
    ADDR = 3'b010,
    DATA = 3'b100
  } arb_state_e;

  localparam logic M_IFU = 1'b0;
  localparam logic M_LSU = 1'b1;

endpackage

// File: rtl/rr_arb2.sv
// Combinational two-way round-robin picker: a lone requester wins,
// a tie goes to whichever master was not granted last.
module rr_arb2
  import arb_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last_grant,
  output logic       grant
);

  always_comb begin
    grant = M_IFU;
    if (req == 2'b11) begin
      grant = ~last_grant;
    end else if (req[1]) begin
      grant = M_LSU;
    end
  end

endmodule

// File: rtl/axi_lite_rd_arbiter.sv
// AXI-Lite read-channel arbiter: IFU (M0) and LSU (M1) share one slave
// read port, one transaction in flight, round-robin on ties.
module axi_lite_rd_arbiter
  import arb_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,

  input  logic              m0_ar_valid_i,
  input  logic [ADDR_W-1:0] m0_ar_addr_i,
  output logic              m0_ar_ready_o,
  output logic              m0_r_valid_o,
  output logic [DATA_W-1:0] m0_r_data_o,
  output logic [1:0]        m0_r_resp_o,
  input  logic              m0_r_ready_i,

  input  logic              m1_ar_valid_i,
  input  logic [ADDR_W-1:0] m1_ar_addr_i,
  output logic              m1_ar_ready_o,
  output logic              m1_r_valid_o,
  output logic [DATA_W-1:0] m1_r_data_o,
  output logic [1:0]        m1_r_resp_o,
  input  logic              m1_r_ready_i,

  output logic              s_ar_valid_o,
  output logic [ADDR_W-1:0] s_ar_addr_o,
  input  logic              s_ar_ready_i,
  input  logic              s_r_valid_i,
  input  logic [DATA_W-1:0] s_r_data_i,
  input  logic [1:0]        s_r_resp_i,
  output logic              s_r_ready_o,

  output logic              grant_o
);

  arb_state_e state_reg, state_next;
  logic       grant_reg, grant_next;
  logic       last_reg, last_next;
  logic       pick;
  logic       owner_r_ready;

  rr_arb2 u_rr_arb2 (
    .req        ({m1_ar_valid_i, m0_ar_valid_i}),
    .last_grant (last_reg),
    .grant      (pick)
  );

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state_reg <= IDLE;
      grant_reg <= M_IFU;
      last_reg  <= M_IFU;
    end else begin
      state_reg <= state_next;
      grant_reg <= grant_next;
      last_reg  <= last_next;
    end
  end

  assign owner_r_ready = (grant_reg == M_LSU) ? m1_r_ready_i : m0_r_ready_i;

  always_comb begin
    state_next    = state_reg;
    grant_next    = grant_reg;
    last_next     = last_reg;
    s_ar_valid_o  = 1'b0;
    s_ar_addr_o   = '0;
    s_r_ready_o   = 1'b0;
    m0_ar_ready_o = 1'b0;
    m1_ar_ready_o = 1'b0;
    m0_r_valid_o  = 1'b0;
    m1_r_valid_o  = 1'b0;

    unique case (state_reg)
      IDLE: begin
        if (m0_ar_valid_i || m1_ar_valid_i) begin
          grant_next = pick;
          state_next = ADDR;
        end
      end

      ADDR: begin
        s_ar_valid_o  = 1'b1;
        s_ar_addr_o   = (grant_reg == M_LSU) ? m1_ar_addr_i : m0_ar_addr_i;
        m0_ar_ready_o = (grant_reg == M_IFU) && s_ar_ready_i;
        m1_ar_ready_o = (grant_reg == M_LSU) && s_ar_ready_i;
        if (s_ar_ready_i) begin
          state_next = DATA;
        end
      end

      DATA: begin
        // Only the owner sees r_valid; data and resp are broadcast below.
        s_r_ready_o  = owner_r_ready;
        m0_r_valid_o = (grant_reg == M_IFU) && s_r_valid_i;
        m1_r_valid_o = (grant_reg == M_LSU) && s_r_valid_i;
        if (s_r_valid_i && owner_r_ready) begin
          state_next = IDLE;
          last_next  = grant_reg;
        end
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign m0_r_data_o = s_r_data_i;
  assign m1_r_data_o = s_r_data_i;
  assign m0_r_resp_o = s_r_resp_i;
  assign m1_r_resp_o = s_r_resp_i;
  assign grant_o     = grant_reg;

endmodule

// File: tb/tb_axi_lite_rd_arbiter.sv
// Directed bench for axi_lite_rd_arbiter: single requester, ties,
// alternation, slave back-pressure, busy-time request and mid-transfer reset.
module tb_axi_lite_rd_arbiter;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        m0_ar_valid_i, m1_ar_valid_i;
  logic [31:0] m0_ar_addr_i, m1_ar_addr_i;
  logic        m0_ar_ready_o, m1_ar_ready_o;
  logic        m0_r_valid_o, m1_r_valid_o;
  logic [31:0] m0_r_data_o, m1_r_data_o;
  logic [1:0]  m0_r_resp_o, m1_r_resp_o;
  logic        m0_r_ready_i, m1_r_ready_i;
  logic        s_ar_valid_o;
  logic [31:0] s_ar_addr_o;
  logic        s_ar_ready_i;
  logic        s_r_valid_i;
  logic [31:0] s_r_data_i;
  logic [1:0]  s_r_resp_i;
  logic        s_r_ready_o;
  logic        grant_o;

  int vectors = 0;
  int miscompares = 0;

  axi_lite_rd_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .m0_ar_valid_i (m0_ar_valid_i),
    .m0_ar_addr_i  (m0_ar_addr_i),
    .m0_ar_ready_o (m0_ar_ready_o),
    .m0_r_valid_o  (m0_r_valid_o),
    .m0_r_data_o   (m0_r_data_o),
    .m0_r_resp_o   (m0_r_resp_o),
    .m0_r_ready_i  (m0_r_ready_i),
    .m1_ar_valid_i (m1_ar_valid_i),
    .m1_ar_addr_i  (m1_ar_addr_i),
    .m1_ar_ready_o (m1_ar_ready_o),
    .m1_r_valid_o  (m1_r_valid_o),
    .m1_r_data_o   (m1_r_data_o),
    .m1_r_resp_o   (m1_r_resp_o),
    .m1_r_ready_i  (m1_r_ready_i),
    .s_ar_valid_o  (s_ar_valid_o),
    .s_ar_addr_o   (s_ar_addr_o),
    .s_ar_ready_i  (s_ar_ready_i),
    .s_r_valid_i   (s_r_valid_i),
    .s_r_data_i    (s_r_data_i),
    .s_r_resp_i    (s_r_resp_i),
    .s_r_ready_o   (s_r_ready_o),
    .grant_o       (grant_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Start in IDLE with request valids already driven; slave answers at once.
  task automatic txn(input logic g, input logic [31:0] a, input logic [31:0] d,
                     input logic [1:0] rsp);
    s_ar_ready_i = 1'b1;
    s_r_valid_i  = 1'b1;
    s_r_data_i   = d;
    s_r_resp_i   = rsp;
    tick();
    check("addr_s_ar_valid", 32'(s_ar_valid_o), 32'd1);
    check("addr_s_ar_addr", s_ar_addr_o, a);
    check("addr_grant", 32'(grant_o), 32'(g));
    check("addr_ar_ready_owner", 32'(g ? m1_ar_ready_o : m0_ar_ready_o), 32'd1);
    check("addr_ar_ready_other", 32'(g ? m0_ar_ready_o : m1_ar_ready_o), 32'd0);
    check("addr_r_valid_ignored", 32'(m0_r_valid_o | m1_r_valid_o), 32'd0);
    check("addr_s_r_ready", 32'(s_r_ready_o), 32'd0);
    tick();
    check("data_r_valid_owner", 32'(g ? m1_r_valid_o : m0_r_valid_o), 32'd1);
    check("data_r_valid_other", 32'(g ? m0_r_valid_o : m1_r_valid_o), 32'd0);
    check("data_r_data", g ? m1_r_data_o : m0_r_data_o, d);
    check("data_r_resp", 32'(g ? m1_r_resp_o : m0_r_resp_o), 32'(rsp));
    check("data_s_ar_valid", 32'(s_ar_valid_o), 32'd0);
    check("data_s_ar_addr_zero", s_ar_addr_o, 32'd0);
    check("data_s_r_ready", 32'(s_r_ready_o), 32'd1);
    $display("txn: grant=%0d addr=0x%08h data=0x%08h resp=%0d", g, a, d, rsp);
  endtask

  task automatic check_quiet(input string tag);
    check({tag, "_s_ar_valid"}, 32'(s_ar_valid_o), 32'd0);
    check({tag, "_s_ar_addr"}, s_ar_addr_o, 32'd0);
    check({tag, "_s_r_ready"}, 32'(s_r_ready_o), 32'd0);
    check({tag, "_ar_ready"}, 32'({m1_ar_ready_o, m0_ar_ready_o}), 32'd0);
    check({tag, "_r_valid"}, 32'({m1_r_valid_o, m0_r_valid_o}), 32'd0);
  endtask

  initial begin
    logic [31:0] alt_addr;

    rst_i = 1'b0;
    m0_ar_valid_i = 1'b0; m1_ar_valid_i = 1'b0;
    m0_ar_addr_i = 32'h0; m1_ar_addr_i = 32'h0;
    m0_r_ready_i = 1'b1; m1_r_ready_i = 1'b1;
    s_ar_ready_i = 1'b0; s_r_valid_i = 1'b0;
    s_r_data_i = 32'h0; s_r_resp_i = 2'b00;
    tick();
    tick();
    check_quiet("reset");
    check("reset_grant", 32'(grant_o), 32'd0);
    rst_i = 1'b1;
    tick();

    // Lone IFU fetch, minimum latency.
    m0_ar_valid_i = 1'b1; m0_ar_addr_i = 32'h8000_0000;
    #1;
    check("t0_s_ar_valid", 32'(s_ar_valid_o), 32'd0);
    txn(1'b0, 32'h8000_0000, 32'h0000_0413, 2'b00);
    m0_ar_valid_i = 1'b0;
    tick();
    check_quiet("t1_idle");

    // Simultaneous requests: LSU wins the first tie.
    m0_ar_valid_i = 1'b1; m0_ar_addr_i = 32'h8000_0004;
    m1_ar_valid_i = 1'b1; m1_ar_addr_i = 32'h8000_1000;
    txn(1'b1, 32'h8000_1000, 32'h1111_0001, 2'b00);
    m1_ar_valid_i = 1'b0;
    tick();
    txn(1'b0, 32'h8000_0004, 32'h2222_0002, 2'b00);
    m0_ar_valid_i = 1'b0;
    tick();

    // Both hold requests: grants alternate starting with LSU.
    m0_ar_valid_i = 1'b1; m0_ar_addr_i = 32'h8000_0100;
    m1_ar_valid_i = 1'b1; m1_ar_addr_i = 32'h8000_2100;
    for (int i = 0; i < 4; i++) begin
      alt_addr = (i % 2 == 0) ? 32'h8000_2100 : 32'h8000_0100;
      txn((i % 2 == 0) ? 1'b1 : 1'b0, alt_addr, 32'hA000_0000 + 32'(i), 2'b00);
      tick();
      check("alt_bubble", 32'(s_ar_valid_o), 32'd0);
    end
    m0_ar_valid_i = 1'b0; m1_ar_valid_i = 1'b0;

    // Slave stalls the address for 5 cycles then returns SLVERR.
    m0_ar_valid_i = 1'b1; m0_ar_addr_i = 32'h8000_0008;
    s_ar_ready_i = 1'b0; s_r_valid_i = 1'b0;
    tick();
    for (int i = 0; i < 5; i++) begin
      check("stall_s_ar_valid", 32'(s_ar_valid_o), 32'd1);
      check("stall_s_ar_addr", s_ar_addr_o, 32'h8000_0008);
      check("stall_ar_ready", 32'(m0_ar_ready_o), 32'd0);
      tick();
    end
    s_ar_ready_i = 1'b1; s_r_valid_i = 1'b1;
    s_r_data_i = 32'hDEAD_0008; s_r_resp_i = 2'b10;
    #1;
    check("stall_ar_ready_release", 32'(m0_ar_ready_o), 32'd1);
    tick();
    m0_ar_valid_i = 1'b0;
    check("stall_r_valid", 32'(m0_r_valid_o), 32'd1);
    check("stall_r_resp", 32'(m0_r_resp_o), 32'd2);
    $display("txn: grant=0 addr=0x80000008 stalled 5 cycles resp=2");
    tick();

    // LSU request arrives while IFU waits for delayed data.
    m0_ar_valid_i = 1'b1; m0_ar_addr_i = 32'h8000_000C;
    s_ar_ready_i = 1'b1; s_r_valid_i = 1'b0; s_r_resp_i = 2'b00;
    tick();
    m0_ar_valid_i = 1'b0;
    tick();
    m1_ar_valid_i = 1'b1; m1_ar_addr_i = 32'h8000_2000;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("busy_m0_r_valid", 32'(m0_r_valid_o), 32'd0);
      check("busy_s_ar_valid", 32'(s_ar_valid_o), 32'd0);
      check("busy_grant", 32'(grant_o), 32'd0);
      tick();
    end
    s_r_valid_i = 1'b1; s_r_data_i = 32'h0000_C0DE;
    #1;
    check("busy_m0_r_valid_late", 32'(m0_r_valid_o), 32'd1);
    check("busy_m1_r_valid", 32'(m1_r_valid_o), 32'd0);
    tick();
    check("busy_bubble", 32'(s_ar_valid_o), 32'd0);
    check("busy_bubble_m1_ar_ready", 32'(m1_ar_ready_o), 32'd0);
    $display("txn: grant=0 addr=0x8000000c data delayed 3 cycles");
    txn(1'b1, 32'h8000_2000, 32'h0000_BEEF, 2'b00);
    m1_ar_valid_i = 1'b0;
    tick();

    // Reset during DATA; last-grant must return to IFU so LSU wins the next tie.
    m0_ar_valid_i = 1'b1; m0_ar_addr_i = 32'h8000_0010;
    s_ar_ready_i = 1'b1; s_r_valid_i = 1'b0;
    tick();
    m0_ar_valid_i = 1'b0;
    tick();
    check("rst_pre_s_r_ready", 32'(s_r_ready_o), 32'd1);
    rst_i = 1'b0;
    tick();
    check_quiet("rst_mid");
    check("rst_mid_grant", 32'(grant_o), 32'd0);
    rst_i = 1'b1;
    m0_ar_valid_i = 1'b1; m0_ar_addr_i = 32'h8000_0014;
    m1_ar_valid_i = 1'b1; m1_ar_addr_i = 32'h8000_3000;
    tick();
    check("rst_tie_grant", 32'(grant_o), 32'd1);
    check("rst_tie_addr", s_ar_addr_o, 32'h8000_3000);
    $display("txn: reset in DATA, next tie grant=%0d", grant_o);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
